// File: rtl/ripple_count_capture.sv
// Clean capture of a 4-bit ripple counter: stability filter, wrap extension and skip detection.
// Optional build macro RIPPLE_CAPTURE_OVF_EN adds a sticky ovf output for extension overflow.
module ripple_count_capture #(
  parameter int EXT_WIDTH     = 8,
  parameter int STABLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             cnt_in,
  input  logic                   clr_err,
  output logic [EXT_WIDTH+3:0]   count_ext,
  output logic                   count_valid,
  output logic                   wrap_pulse,
  output logic                   skip_err
`ifdef RIPPLE_CAPTURE_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam logic [2:0] STAB_TGT = 3'(STABLE_CYCLES - 1);
  localparam logic [2:0] STAB_MAX = 3'd7;

  logic [1:0]           r_state;
  logic [3:0]           r_samp;
  logic [2:0]           r_stab;
  logic [3:0]           r_acc_val;
  logic                 r_acc_vld;
  logic [3:0]           r_nib;
  logic [EXT_WIDTH-1:0] r_upper;
  logic                 r_valid;
  logic                 r_wrap;
  logic                 r_skip;

  logic                 w_raw_accept;
  logic                 w_accept;
  logic [3:0]           w_nib_inc;
  logic [1:0]           w_state_nxt;
  logic [3:0]           w_nib_nxt;
  logic [EXT_WIDTH-1:0] w_upper_nxt;
  logic                 w_valid_nxt;
  logic                 w_wrap_nxt;
  logic                 w_skip_nxt;

  // A value counts once it has been seen on STABLE_CYCLES consecutive edges and
  // differs from the last accepted value, so a held value never re-fires.
  assign w_raw_accept = (STABLE_CYCLES == 1) ||
                        ((cnt_in == r_samp) && (r_stab == STAB_TGT));
  assign w_accept     = w_raw_accept && !(r_acc_vld && (cnt_in == r_acc_val));
  assign w_nib_inc    = r_nib + 4'd1;

`ifdef RIPPLE_CAPTURE_OVF_EN
  logic r_ovf;
  logic w_ovf_set;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_nib_nxt   = r_nib;
    w_upper_nxt = r_upper;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_skip_nxt  = r_skip;
`ifdef RIPPLE_CAPTURE_OVF_EN
    w_ovf_set   = 1'b0;
`endif
    case (r_state)
      ST_ACQ: begin
        if (w_accept) begin
          w_nib_nxt   = cnt_in;
          w_upper_nxt = '0;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_accept && (cnt_in != r_nib)) begin
          if (cnt_in == w_nib_inc) begin
            w_nib_nxt = cnt_in;
            if (r_nib == 4'hF) begin
              w_upper_nxt = r_upper + 1'b1;
              w_wrap_nxt  = 1'b1;
`ifdef RIPPLE_CAPTURE_OVF_EN
              w_ovf_set   = &r_upper;
`endif
            end
          end else begin
            w_skip_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        // clr_err takes priority over any acceptance in the same cycle.
        if (clr_err) begin
          w_skip_nxt  = 1'b0;
          w_state_nxt = ST_ACQ;
        end
      end
      default: w_state_nxt = ST_ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACQ;
      r_samp    <= 4'd0;
      r_stab    <= 3'd0;
      r_acc_val <= 4'd0;
      r_acc_vld <= 1'b0;
      r_nib     <= 4'd0;
      r_upper   <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_samp <= cnt_in;
      if (cnt_in == r_samp) begin
        r_stab <= (r_stab == STAB_MAX) ? r_stab : r_stab + 3'd1;
      end else begin
        r_stab <= 3'd1;
      end
      if (w_accept) begin
        r_acc_val <= cnt_in;
        r_acc_vld <= 1'b1;
      end
      r_state <= w_state_nxt;
      r_nib   <= w_nib_nxt;
      r_upper <= w_upper_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

`ifdef RIPPLE_CAPTURE_OVF_EN
  // Sticky until rst; clr_err deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign count_ext   = {r_upper, r_nib};
  assign count_valid = r_valid;
  assign wrap_pulse  = r_wrap;
  assign skip_err    = r_skip;

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit ripple carry counter output.
- Samples the counter's 4-bit value in the clk domain and filters it for stability, since ripple outputs settle bit by bit.
- Extends the count with EXT_WIDTH upper bits on each 15->0 wrap, emits a wrap pulse, and flags any non-sequential step as a sticky error.
- Feeds system logic that needs a wide, clean, monotonic count.

Parameters:
EXT_WIDTH, 8, number of extension bits above the 4-bit counter value; legal 1..24
STABLE_CYCLES, 1, consecutive rising edges at which cnt_in must be equal before acceptance; legal 1..4 (1 for same-clock operation with the counter, >1 when the counter runs slower or asynchronously)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cnt_in  input  4  counter value from ripple counter (its q output)
clr_err  input  1  synchronous request to clear error and reacquire
count_ext  output  EXT_WIDTH+4  extended count {upper, accepted nibble}
count_valid  output  1  count_ext is tracking a sequential count
wrap_pulse  output  1  one-cycle pulse on accepted 15->0 transition
skip_err  output  1  sticky: an accepted value was not last+1 mod 16

Behaviour:
- Reset (rst=1 at a rising edge): count_ext=0, count_valid=0, wrap_pulse=0, skip_err=0. Internal state: state=ACQ, sample register=0, stable counter=0. rst overrides clr_err and all other activity, including mid-operation.
- Stability filter:
  - samp<=cnt_in each edge.
  - stab<=(cnt_in==samp) ? sat(stab+1) : 1.
  - Candidate v=cnt_in is accepted at the edge where it has been seen on STABLE_CYCLES consecutive edges, i.e. (STABLE_CYCLES==1) or (cnt_in==samp && stab==STABLE_CYCLES-1).
  - Acceptance is a single event per distinct value: once a value is accepted, re-seeing the same value is not a new acceptance.
  - Outputs update at the accepting edge (latency: visible after STABLE_CYCLES-th equal edge).
- FSM states: ACQ, TRACK, ERR.
  - ACQ: count_valid=0. On first acceptance of v: count_ext<={0,v}, count_valid<=1, go to TRACK. No wrap_pulse or skip_err is generated in ACQ.
  - TRACK, on acceptance of v != nibble:
    - v==nibble+1, no wrap: nibble<=v.
    - nibble==15 and v==0: nibble<=0, upper<=upper+1 mod 2^EXT_WIDTH, wrap_pulse=1 for exactly that cycle.
    - Otherwise: skip_err<=1, count_valid<=0, count_ext holds its last good value, go to ERR.
  - TRACK, acceptance of v==nibble: no change.
  - ERR: outputs frozen; cnt_in is still filtered but ignored.
  - clr_err=1 in ERR: skip_err<=0, go to ACQ (count_ext unchanged until reacquire). clr_err is ignored in ACQ and TRACK.
- Simultaneous events:
  - clr_err and an acceptance in the same ERR cycle: clr_err wins; the acceptance is discarded and the next acceptance is evaluated in ACQ.
- Upper overflow: wraps silently to 0 unless the optional feature is enabled.
- wrap_pulse is 0 in every cycle except an accepted 15->0 step in TRACK.

Optional Feature:
- Macro RIPPLE_CAPTURE_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), set sticky when upper wraps from all-ones to 0 together with that cycle's wrap_pulse.
  - Cleared only by rst, not by clr_err.
- Undefined: no ovf port; upper wraps silently.

Test Plan:
1. Reset, then drive cnt_in 0,1,2,...,15,0,1 one per clk, STABLE_CYCLES=1 -> count_valid=1 after first edge. count_ext goes 0x000..0x00F then 0x010, 0x011. wrap_pulse high exactly one cycle at the 15->0 edge. skip_err=0 throughout.
2. STABLE_CYCLES=2; drive cnt_in glitch 3->7(1 cycle)->4 held 2 cycles from nibble 3 -> glitch value 7 is never accepted. count_ext low nibble becomes 4 after second edge of 4. No skip_err.
3. From TRACK at nibble 5, hold cnt_in=8 -> skip_err=1, count_valid=0, count_ext holds 0x005. Pulse clr_err, then drive 9 -> state ACQ, count_ext=0x009, count_valid=1, skip_err=0.
4. Assert rst for one cycle while in TRACK at count_ext=0x02A -> all outputs 0 after that edge. Next accepted value reacquires from upper=0.
5. EXT_WIDTH=1 with RIPPLE_CAPTURE_OVF_EN defined; run three full 0..15 cycles -> upper 0->1->0 (wrap). ovf=1 from the second wrap onward. clr_err does not clear ovf; rst does.
6. In ERR, assert clr_err in the same cycle a new value is accepted -> clr_err wins. Value discarded, state ACQ, next accepted value loads count_ext.
